// File: rtl/fx2fp_pkg.sv
// Shared types and helpers for the fixed-point to float converter.
package fx2fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    NORM,
    ROUND,
    DONE
  } state_t;

  typedef enum logic {
    RND_TRUNC,
    RND_RNE
  } rnd_t;

  // Exponent bias for an exponent field of the given width.
  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fx2fp_round.sv
// Rounding and exponent adjust for a normalised magnitude.
// frac is the normalised magnitude without its leading 1.
module fx2fp_round
  import fx2fp_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [IN_W-2:0]          frac,
  input  logic signed [EXP_W+1:0]  exp_in,
  input  rnd_t                     mode,
  output logic [EXP_W+MAN_W-1:0]   em_out,
  output logic                     ovf,
  output logic                     unf
);

  // Fraction padded so kept, guard and at least one sticky bit always exist.
  localparam int EXT_W = IN_W - 1 + MAN_W + 2;
  localparam logic signed [EXP_W+1:0] EXP_TOP  = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] EXP_ZERO = '0;

  logic [EXT_W-1:0]        ext;
  logic [MAN_W-1:0]        kept;
  logic                    guard;
  logic                    sticky;
  logic                    inc;
  logic [MAN_W:0]          sum;
  logic                    carry;
  logic signed [EXP_W+1:0] exp_r;

  // Split the fraction, apply the rounding increment and clamp flags.
  always_comb begin
    ext    = {frac, {(MAN_W+2){1'b0}}};
    kept   = ext[EXT_W-1 -: MAN_W];
    guard  = ext[EXT_W-1-MAN_W];
    sticky = |ext[EXT_W-2-MAN_W:0];
    inc    = (mode == RND_RNE) & guard & (sticky | kept[0]);
    sum    = {1'b0, kept} + {{MAN_W{1'b0}}, inc};
    carry  = sum[MAN_W];
    exp_r  = exp_in + $signed({{(EXP_W+1){1'b0}}, carry});
    ovf    = (exp_r >= EXP_TOP);
    unf    = (exp_r <= EXP_ZERO);
    // On carry-out the low mantissa bits of sum are already all zero.
    em_out = {exp_r[EXP_W-1:0], sum[MAN_W-1:0]};
  end

endmodule

// File: rtl/fx2fp_conv.sv
// Iterative signed fixed-point to float converter, start/ack handshake.
// Normalises one bit per clock, then rounds (truncate or RNE) and packs.
module fx2fp_conv
  import fx2fp_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 8,
  parameter int EXP_W  = 5,
  parameter int MAN_W  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rnd_mode,
  input  logic [IN_W-1:0]        fx_in,
  output logic [EXP_W+MAN_W:0]   flt_out,
  output logic                   ack,
  output logic                   busy
);

  localparam logic signed [EXP_W+1:0] EXP_INIT =
    (EXP_W+2)'(IN_W - FRAC_W - 1 + int'(bias(EXP_W)));
  localparam logic signed [EXP_W+1:0] EXP_ONE = (EXP_W+2)'(1);

  state_t                  state;
  logic [IN_W-1:0]         fx_q;
  rnd_t                    rnd_q;
  logic                    sign_q;
  logic [IN_W-1:0]         mag_q;
  logic signed [EXP_W+1:0] exp_q;

  logic [EXP_W+MAN_W-1:0]  em;
  logic                    ovf;
  logic                    unf;
  logic [EXP_W+MAN_W:0]    result;

  fx2fp_round #(
    .IN_W  (IN_W),
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .frac   (mag_q[IN_W-2:0]),
    .exp_in (exp_q),
    .mode   (rnd_q),
    .em_out (em),
    .ovf    (ovf),
    .unf    (unf)
  );

  // Final packing: zero magnitude, infinity and flush-to-zero cases.
  always_comb begin
    result = '0;
    if (mag_q == '0) begin
      result = '0;
    end else if (ovf) begin
      result = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (unf) begin
      result = {sign_q, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      result = {sign_q, em};
    end
  end

  // Control FSM with capture, normalising shifter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      fx_q    <= '0;
      rnd_q   <= RND_TRUNC;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      flt_out <= '0;
      ack     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            fx_q  <= fx_in;
            rnd_q <= rnd_mode ? RND_RNE : RND_TRUNC;
            ack   <= 1'b0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          sign_q <= fx_q[IN_W-1];
          mag_q  <= fx_q[IN_W-1] ? (~fx_q + IN_W'(1)) : fx_q;
          exp_q  <= EXP_INIT;
          // Zero also passes through NORM (exits at once) so its
          // latency matches a magnitude with no leading zeros.
          state  <= NORM;
        end
        NORM: begin
          if (mag_q[IN_W-1] || (mag_q == '0)) begin
            state <= ROUND;
          end else begin
            mag_q <= {mag_q[IN_W-2:0], 1'b0};
            exp_q <= exp_q - EXP_ONE;
          end
        end
        ROUND: begin
          flt_out <= result;
          ack     <= 1'b1;
          busy    <= 1'b0;
          state   <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
